// File: rtl/mux_4_to_1_3_bit.sv
// 4-to-1 mux with a combinational output plus an enable-gated registered copy
// that keeps the captured data and select paired, and a valid flag.
module mux_4_to_1_3_bit #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] out_d;
  logic [1:0]       sel_d;
  logic             out_valid_d;
  logic             out_valid_q;

  // An unknown select propagates as all-X; every path assigns, so no latch.
  always_comb begin
    mux_y = {WIDTH{1'bx}};
    case (sel)
      2'd0:    mux_y = i0;
      2'd1:    mux_y = i1;
      2'd2:    mux_y = i2;
      2'd3:    mux_y = i3;
      default: mux_y = {WIDTH{1'bx}};
    endcase
  end

  assign out = mux_y;

  // Data and select are loaded under the same enable so out_q always matches sel_q.
  always_comb begin
    out_d       = out_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    if (en) begin
      out_d       = mux_y;
      sel_d       = sel;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_4_to_1_3_bit.sv
// Scoreboard bench: the driver pushes hand-computed expectations per vector,
// a monitor pops one per clock after the capturing edge and compares.
module tb_mux_4_to_1_3_bit;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] sel3;
  logic [2:0] i0, i1, i2, i3;
  logic [2:0] out;
  logic [2:0] out_q;
  logic [1:0] sel_q;
  logic       out_valid;

  typedef struct {
    int         idx;
    logic [2:0] exp_out;
    logic [2:0] exp_out_q;
    logic [1:0] exp_sel_q;
    logic       exp_valid;
  } exp_t;

  exp_t sb[$];
  int   n_vectors;
  int   n_compares;
  int   n_miscompares;

  // sel comes from a 3-bit source; the 2-bit port keeps only the low bits.
  mux_4_to_1_3_bit #(.WIDTH(3)) dut (
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .sel(sel3[1:0]),
    .out(out),
    .clk(clk),
    .rst(rst),
    .en(en),
    .out_q(out_q),
    .sel_q(sel_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector mid-cycle; it is captured on the next rising edge.
  task automatic apply(input logic r, input logic e, input logic [2:0] s,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [2:0] a2, input logic [2:0] a3,
                       input logic [2:0] eo, input logic [2:0] eoq,
                       input logic [1:0] esq, input logic ev);
    exp_t x;
    @(negedge clk);
    #2;
    rst = r; en = e; sel3 = s;
    i0 = a0; i1 = a1; i2 = a2; i3 = a3;
    x.idx = n_vectors; x.exp_out = eo; x.exp_out_q = eoq;
    x.exp_sel_q = esq; x.exp_valid = ev;
    sb.push_back(x);
    n_vectors++;
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      $display("vec %0d: sel=%0d en=%0d rst=%0d out=%0d out_q=%0d sel_q=%0d valid=%0d",
               x.idx, sel3, en, rst, out, out_q, sel_q, out_valid);
      n_compares++;
      if (out !== x.exp_out) begin
        n_miscompares++;
        $display("FAIL vec %0d out: got %b expected %b", x.idx, out, x.exp_out);
      end
      n_compares++;
      if (out_q !== x.exp_out_q) begin
        n_miscompares++;
        $display("FAIL vec %0d out_q: got %b expected %b", x.idx, out_q, x.exp_out_q);
      end
      n_compares++;
      if (sel_q !== x.exp_sel_q) begin
        n_miscompares++;
        $display("FAIL vec %0d sel_q: got %b expected %b", x.idx, sel_q, x.exp_sel_q);
      end
      n_compares++;
      if (out_valid !== x.exp_valid) begin
        n_miscompares++;
        $display("FAIL vec %0d out_valid: got %b expected %b", x.idx, out_valid, x.exp_valid);
      end
    end
  end

  initial begin
    int waited;
    n_vectors = 0; n_compares = 0; n_miscompares = 0;
    rst = 1'b1; en = 1'b0; sel3 = 3'd0;
    i0 = 3'd0; i1 = 3'd1; i2 = 3'd2; i3 = 3'd3;

    //     rst  en   sel   i0 i1 i2 i3   out oq  sq  v
    apply(1'b1, 1'b1, 3'd0, 0, 1, 2, 3,  0,  0,  0, 1'b0); // reset wins over en
    apply(1'b0, 1'b0, 3'd0, 0, 1, 2, 3,  0,  0,  0, 1'b0); // valid stays low without en
    apply(1'b0, 1'b0, 3'd1, 0, 1, 2, 3,  1,  0,  0, 1'b0);
    apply(1'b0, 1'b0, 3'd2, 0, 1, 2, 3,  2,  0,  0, 1'b0);
    apply(1'b0, 1'b0, 3'd3, 0, 1, 2, 3,  3,  0,  0, 1'b0);
    apply(1'b0, 1'b0, 3'd4, 0, 1, 2, 3,  0,  0,  0, 1'b0); // sel 4..7 truncate
    apply(1'b0, 1'b0, 3'd5, 0, 1, 2, 3,  1,  0,  0, 1'b0);
    apply(1'b0, 1'b0, 3'd6, 0, 1, 2, 3,  2,  0,  0, 1'b0);
    apply(1'b0, 1'b0, 3'd7, 0, 1, 2, 3,  3,  0,  0, 1'b0);
    apply(1'b1, 1'b0, 3'd2, 0, 1, 2, 3,  2,  0,  0, 1'b0);
    apply(1'b0, 1'b1, 3'd2, 0, 1, 2, 3,  2,  2,  2, 1'b1); // first capture
    apply(1'b0, 1'b0, 3'd3, 0, 1, 2, 3,  3,  2,  2, 1'b1); // hold with en low
    apply(1'b0, 1'b0, 3'd3, 0, 1, 2, 3,  3,  2,  2, 1'b1);
    apply(1'b0, 1'b1, 3'd3, 0, 1, 2, 3,  3,  3,  3, 1'b1);
    apply(1'b1, 1'b1, 3'd3, 0, 1, 2, 3,  3,  0,  0, 1'b0); // mid-run reset, out still live
    apply(1'b0, 1'b0, 3'd3, 0, 1, 2, 3,  3,  0,  0, 1'b0);
    apply(1'b0, 1'b1, 3'd1, 5, 6, 7, 4,  6,  6,  1, 1'b1); // all data + sel change at once
    apply(1'b0, 1'b1, 3'd1, 2, 3, 4, 5,  3,  3,  1, 1'b1);
    apply(1'b0, 1'b1, 3'd2, 7, 0, 1, 6,  1,  1,  2, 1'b1);
    apply(1'b0, 1'b1, 3'd0, 4, 5, 6, 7,  4,  4,  0, 1'b1);
    apply(1'b0, 1'b0, 3'd3, 1, 2, 3, 0,  0,  4,  0, 1'b1);

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #5;
    if (sb.size() > 0) begin
      n_miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
